// File: rtl/sensor_feeder_pkg.sv
// Shared constants and helpers for the sensor byte feeder.
package sensor_feeder_pkg;

    // Width of every quantized byte handed to the isolation-tree stage.
    localparam int BYTE_W = 8;

    // FIFO depth used when the instantiating design does not override it.
    localparam int DEFAULT_DEPTH = 16;

    // Occupancy counter width: must represent 0..depth inclusive.
    function automatic int level_width(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/sample_quantizer.sv
// Combinational conversion of a raw unsigned sensor sample into one byte:
// remove the baseline (clamping at zero), scale down by a right shift and
// saturate anything that no longer fits in a byte.
module sample_quantizer
    import sensor_feeder_pkg::*;
#(
    parameter int          IN_W   = 12,
    parameter int unsigned OFFSET = 0,
    parameter int          SHIFT  = 4
) (
    input  logic [IN_W-1:0]   sample,
    output logic [BYTE_W-1:0] quantized
);

    localparam logic [IN_W-1:0]        OFFSET_V = IN_W'(OFFSET);
    localparam logic [IN_W+BYTE_W-1:0] BYTE_MAX = (IN_W + BYTE_W)'(255);

    logic [IN_W-1:0]        diff;
    logic [IN_W-1:0]        shifted;
    logic [IN_W+BYTE_W-1:0] widened;

    // Baseline removal, scaling and saturation; widening keeps narrow IN_W legal.
    always_comb begin
        diff    = (sample < OFFSET_V) ? '0 : (sample - OFFSET_V);
        shifted = diff >> SHIFT;
        widened = {{BYTE_W{1'b0}}, shifted};
        if (widened > BYTE_MAX) begin
            quantized = 8'hFF;
        end else begin
            quantized = widened[BYTE_W-1:0];
        end
    end

endmodule

// File: rtl/sensor_byte_feeder.sv
// Quantizes raw sensor samples and buffers the resulting bytes in a small
// FIFO, issuing one registered byte per cycle when the tree stage allows it.
module sensor_byte_feeder
    import sensor_feeder_pkg::*;
#(
    parameter int          IN_W    = 12,
    parameter int unsigned OFFSET  = 0,
    parameter int          SHIFT   = 4,
    parameter int          DEPTH   = DEFAULT_DEPTH,
    localparam int         LEVEL_W = level_width(DEPTH)
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [IN_W-1:0]    in_sample,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic               clear,
    input  logic               out_enable,
    output logic [BYTE_W-1:0]  data_input,
    output logic               data_valid,
    output logic [LEVEL_W-1:0] level,
    output logic               overflow
);

    localparam int                 PTR_W      = $clog2(DEPTH);
    localparam logic [LEVEL_W-1:0] FULL_LEVEL = LEVEL_W'(DEPTH);

    logic [BYTE_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [BYTE_W-1:0] quantized;
    logic              push;
    logic              pop;
    logic              drop;

    sample_quantizer #(
        .IN_W   (IN_W),
        .OFFSET (OFFSET),
        .SHIFT  (SHIFT)
    ) u_quantizer (
        .sample    (in_sample),
        .quantized (quantized)
    );

    assign in_ready = (level != FULL_LEVEL);

    // Transfer qualifiers; clear suppresses every transfer and the drop flag.
    always_comb begin
        push = in_valid && in_ready && !clear;
        pop  = out_enable && (level != '0) && !clear;
        drop = in_valid && !in_ready && !clear;
    end

    // Byte storage is deliberately unreset; the level counter guards every read.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= quantized;
        end
    end

    // Pointers, occupancy, sticky overflow and the registered output byte.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            level      <= '0;
            overflow   <= 1'b0;
            data_valid <= 1'b0;
            data_input <= '0;
        end else if (clear) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            level      <= '0;
            overflow   <= 1'b0;
            data_valid <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr     <= rd_ptr + PTR_W'(1);
                data_input <= mem[rd_ptr];
            end
            data_valid <= pop;
            case ({push, pop})
                2'b10:   level <= level + LEVEL_W'(1);
                2'b01:   level <= level - LEVEL_W'(1);
                default: level <= level;
            endcase
            if (drop) begin
                overflow <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_sensor_byte_feeder.sv
// Scoreboard bench for sensor_byte_feeder: stimulus pushes hand-computed
// expected bytes into a queue, a monitor pops and compares each issued byte.
module tb_sensor_byte_feeder;

    logic        clk;
    logic        reset;

    logic [11:0] in_sample;
    logic        in_valid;
    logic        in_ready;
    logic        clear;
    logic        out_enable;
    logic [7:0]  data_input;
    logic        data_valid;
    logic [4:0]  level;
    logic        overflow;

    logic [11:0] sat_sample;
    logic        sat_valid;
    logic        sat_ready;
    logic        sat_enable;
    logic [7:0]  sat_data_input;
    logic        sat_data_valid;
    logic [2:0]  sat_level;
    logic        sat_overflow;

    logic [7:0]  exp_q [$];
    int          checks;
    int          failures;

    sensor_byte_feeder #(
        .IN_W   (12),
        .OFFSET (32'h100),
        .SHIFT  (4),
        .DEPTH  (16)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .in_sample  (in_sample),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .clear      (clear),
        .out_enable (out_enable),
        .data_input (data_input),
        .data_valid (data_valid),
        .level      (level),
        .overflow   (overflow)
    );

    sensor_byte_feeder #(
        .IN_W   (12),
        .OFFSET (0),
        .SHIFT  (0),
        .DEPTH  (4)
    ) dut_sat (
        .clk        (clk),
        .reset      (reset),
        .in_sample  (sat_sample),
        .in_valid   (sat_valid),
        .in_ready   (sat_ready),
        .clear      (1'b0),
        .out_enable (sat_enable),
        .data_input (sat_data_input),
        .data_valid (sat_data_valid),
        .level      (sat_level),
        .overflow   (sat_overflow)
    );

    // Free-running clock, rising edges at 5, 15, 25 ...
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Hard stop in case the sequence ever stalls.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time expired, required end of sequence");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic check_output(input string name, input logic [31:0] actual,
                                input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got 0x%0h, required 0x%0h", name, actual, expected);
        end
    endtask

    // Drive one sample for one edge; accepted samples queue their expected byte.
    task automatic apply_stimulus(input logic [11:0] sample, input logic [7:0] exp_byte,
                                  input bit accept);
        in_sample = sample;
        in_valid  = 1'b1;
        if (accept) begin
            exp_q.push_back(exp_byte);
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    // Wait (bounded) until every expected byte has been observed.
    task automatic wait_drain();
        for (int i = 0; i < 40 && exp_q.size() != 0; i++) begin
            @(negedge clk);
            #1;
        end
        check_output("drain_complete", exp_q.size(), 0);
    endtask

    // Fill past full (one drop), then pop exactly eight: level 8, overflow 1.
    task automatic fill_and_drain_eight();
        for (int i = 0; i < 17; i++) begin
            apply_stimulus(12'h100 + (12'(8'h40 + i) << 4), 8'(8'h40 + i), i < 16);
        end
        @(negedge clk);
        out_enable = 1'b1;
        repeat (8) @(posedge clk);
        #1;
        out_enable = 1'b0;
        check_output("eight_level", level, 8);
        check_output("eight_overflow", overflow, 1);
    endtask

    // Monitor: every issued byte must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (reset && data_valid) begin
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("[TB] FAIL unexpected_byte: got 0x%0h, required no output", data_input);
            end else begin
                check_output("byte_order", data_input, exp_q.pop_front());
            end
        end
    end

    // Directed sequence.
    initial begin
        int run;
        checks     = 0;
        failures   = 0;
        reset      = 1'b1;
        in_sample  = '0;
        in_valid   = 1'b0;
        clear      = 1'b0;
        out_enable = 1'b0;
        sat_sample = '0;
        sat_valid  = 1'b0;
        sat_enable = 1'b0;
        #2;
        reset = 1'b0;

        // Reset state.
        @(negedge clk);
        check_output("reset_level", level, 0);
        check_output("reset_valid", data_valid, 0);
        check_output("reset_data", data_input, 0);
        check_output("reset_overflow", overflow, 0);
        check_output("reset_ready", in_ready, 1);
        @(posedge clk);
        #1;
        reset = 1'b1;

        // Saturation instance: SHIFT=0, OFFSET=0.
        sat_enable = 1'b1;
        sat_sample = 12'h3FF;
        sat_valid  = 1'b1;
        @(posedge clk);
        #1;
        sat_valid = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (sat_data_valid) break;
        end
        check_output("sat_byte_3ff", sat_data_input, 8'hFF);
        sat_sample = 12'h0AB;
        sat_valid  = 1'b1;
        @(posedge clk);
        #1;
        sat_valid = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (sat_data_valid) break;
        end
        check_output("sat_byte_0ab", sat_data_input, 8'hAB);

        // Quantize and latency: empty FIFO with out_enable high.
        @(negedge clk);
        out_enable = 1'b1;
        apply_stimulus(12'h050, 8'h00, 1'b1);
        @(negedge clk);
        check_output("latency_no_bypass", data_valid, 0);
        check_output("latency_level_one", level, 1);
        @(negedge clk);
        check_output("latency_valid", data_valid, 1);
        check_output("latency_level_zero", level, 0);
        apply_stimulus(12'h180, 8'h08, 1'b1);
        apply_stimulus(12'hFFF, 8'hEF, 1'b1);
        wait_drain();

        // Fill: 17 pushes into 16 entries, then drain back to back.
        out_enable = 1'b0;
        for (int i = 0; i < 17; i++) begin
            apply_stimulus(12'h100 + (12'(i) << 4), 8'(i), i < 16);
        end
        @(negedge clk);
        check_output("full_level", level, 16);
        check_output("full_ready", in_ready, 0);
        check_output("full_overflow", overflow, 1);
        out_enable = 1'b1;
        run = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (data_valid) begin
                run++;
            end else if (run > 0) begin
                break;
            end
        end
        check_output("drain_run_length", run, 16);
        check_output("drain_level", level, 0);
        check_output("overflow_sticky", overflow, 1);
        wait_drain();

        // Concurrency: hold level at 5 while pushing and popping together.
        out_enable = 1'b0;
        for (int i = 0; i < 5; i++) begin
            apply_stimulus(12'h100 + (12'(8'h20 + i) << 4), 8'(8'h20 + i), 1'b1);
        end
        @(negedge clk);
        check_output("concurrent_start_level", level, 5);
        out_enable = 1'b1;
        for (int i = 0; i < 10; i++) begin
            apply_stimulus(12'h100 + (12'(8'h30 + i) << 4), 8'(8'h30 + i), 1'b1);
            @(negedge clk);
            check_output("concurrent_level", level, 5);
        end
        wait_drain();
        out_enable = 1'b0;

        // Clear pulse with a same-cycle sample and out_enable both ignored.
        fill_and_drain_eight();
        clear      = 1'b1;
        in_sample  = 12'h7F0;
        in_valid   = 1'b1;
        out_enable = 1'b1;
        @(posedge clk);
        #1;
        clear    = 1'b0;
        in_valid = 1'b0;
        exp_q.delete();
        check_output("clear_level", level, 0);
        check_output("clear_overflow", overflow, 0);
        check_output("clear_valid", data_valid, 0);
        check_output("clear_ready", in_ready, 1);
        repeat (3) @(negedge clk);
        apply_stimulus(12'h650, 8'h55, 1'b1);
        wait_drain();
        out_enable = 1'b0;

        // Asynchronous reset mid-cycle while a byte is being presented.
        fill_and_drain_eight();
        check_output("pre_reset_valid", data_valid, 1);
        #2;
        reset = 1'b0;
        #1;
        check_output("async_reset_level", level, 0);
        check_output("async_reset_overflow", overflow, 0);
        check_output("async_reset_valid", data_valid, 0);
        check_output("async_reset_data", data_input, 0);
        check_output("async_reset_ready", in_ready, 1);
        exp_q.delete();
        @(posedge clk);
        #1;
        reset      = 1'b1;
        out_enable = 1'b1;
        apply_stimulus(12'h770, 8'h67, 1'b1);
        wait_drain();
        check_output("final_level", level, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
        $finish;
    end

endmodule
